rgb_fade_sequencer: RTL and testbench
=====================================

# rgb_fade_sequencer

Colour-sequencing controller for the RGB LED PWM path. It holds a 4-entry colour table and ramps three 8-bit duty registers linearly from the current colour to each table entry in turn. It holds each colour for a programmable time, then advances with wrap-around. It also owns the 8-bit PWM carrier and drives the RGB LED outputs; board-level polarity inversion is done at the top level.

## Interface
- TICK_DIV, 12_000, clocks per fade/hold tick (1 ms at 12 MHz); ≥ 2
- HOLD_TICKS, 500, ticks each colour is held after reaching target; ≥ 1
- iclk  in  1  system clock; single clock domain
- irst_n  in  1  asynchronous, active-low reset
- ienable  in  1  run sequencer; low freezes duty and returns to IDLE
- iwr  in  1  colour-table write strobe, one clock per write
- iwvwaddr  in  2  table write address
- iwvwdata  in  24  table write data {R[23:16], G[15:8], B[7:0]}
- owvduty  out  24  current duty {R, G, B}, registered
- owvrgbled  out  3  PWM outputs [0]=R [1]=G [2]=B, registered, active-high
- owvidx  out  2  index of current target entry
- owvstate  out  2  0=IDLE, 1=FADE, 2=HOLD

## Operation
- Reset values:
  - Outputs: owvduty=0, owvrgbled=0, owvidx=0, owvstate=IDLE.
  - Internal counters: prescaler=0, hold counter=0, PWM counter=0.
  - Colour table: entry0=FF0000, entry1=00FF00, entry2=0000FF, entry3=000000.
- Table write: when iwr=1, table[iwvwaddr] <= iwvwdata at the clock edge. Writes are accepted in any state. A write to owvidx during FADE retargets the fade; the new target is used from the next tick.
- Tick generator: the prescaler counts 0..TICK_DIV-1 and pulses tick when it equals TICK_DIV-1, then wraps to 0. It is held at 0 in IDLE.
- FSM:
  - IDLE: duty and index are held. ienable=1 -> FADE on the next clock.
  - FADE: on each tick, if duty==table[owvidx] on all three channels -> HOLD with hold counter=0. Otherwise each channel steps by 1 toward its target (+1 if below, -1 if above, unchanged if equal).
  - HOLD: on each tick the hold counter increments. On the tick where the hold counter==HOLD_TICKS-1: owvidx <= owvidx+1 (3 wraps to 0) and -> FADE.
  - Any state with ienable=0 -> IDLE on the next clock. owvidx and owvduty are kept; the hold count is discarded.
- Arithmetic: duty is unsigned 8-bit and never wraps. Stepping is always toward the target, so 00->FF and FF->00 never overflow.
- PWM: the 8-bit carrier counter increments every clock and wraps at 255 (period 256 clocks).
  - owvrgbled[i] <= (carrier < duty_i).
  - Duty 00 gives always low; duty FF gives high for 255 of 256 clocks.
- Simultaneous tick and write to the current index: the step on that tick uses the old target; the new target applies from the following tick.

## Timing
- IDLE->FADE: one clock after ienable rises. The first tick occurs TICK_DIV clocks after FADE is entered.
- Fade duration: D+1 ticks, where D = max channel |target-duty|. That is D steps plus one tick to detect equality.
- Hold: exactly HOLD_TICKS ticks from HOLD entry to the index advance. The first step toward the new target occurs on the next tick after the advance.
- Duty update latency: owvduty changes on the clock edge of the tick. owvrgbled reflects a new duty one clock later.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). After release, sequencing restarts from index 0 with duty 0.

## Test plan
Parameters for all scenarios: TICK_DIV=4, HOLD_TICKS=2.
- Reset, ienable=0 for 1000 clocks -> owvduty=000000, owvrgbled=000, owvidx=0, owvstate=IDLE throughout.
- Raise ienable from reset ->
  - R increments every 4 clocks and reaches FF on tick 255.
  - state=HOLD at tick 256.
  - owvidx=1 at tick 258.
  - Then R decrements and G increments, one step per tick, reaching 00FF00.
- Run a full cycle -> after holding entry3 (000000), owvidx wraps 3->0 and R ramps up again.
- Drop ienable when R=0x40 during FADE ->
  - Next clock state=IDLE, and duty stays 400000 for 500 clocks.
  - Re-raise ienable: R resumes at 0x41 on the first tick, 4 clocks after FADE entry.
- During fade to entry0 at R=0x20, write entry0=100000 ->
  - R decrements to 0x10, then HOLD.
  - The write landing exactly on a tick still steps once toward the old target.
- Force a hold with duty R=0x80 (entry0=800000) ->
  - owvrgbled[0] is high for exactly 128 of every 256 clocks.
  - owvrgbled[1] and owvrgbled[2] are never high.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
//   Steps a 24-bit {R,G,B} duty linearly toward each of four colour-table
//   entries in turn, holds each colour for HOLD_TICKS ticks, then moves to
//   the next entry (3 wraps to 0). It also generates the 8-bit PWM carrier
//   and drives active-high per-channel LED outputs.
//
// Parameters
//   TICK_DIV   clocks per fade/hold tick (>= 2)
//   HOLD_TICKS ticks each colour is held once reached (>= 1)
//
// Ports
//   iclk       system clock
//   irst_n     asynchronous active-low reset
//   ienable    run sequencer; low freezes duty and returns to IDLE
//   iwr        colour-table write strobe (one clock per write)
//   iwvwaddr   table write address
//   iwvwdata   table write data {R,G,B}
//   owvduty    current duty {R,G,B}
//   owvrgbled  PWM outputs [0]=R [1]=G [2]=B
//   owvidx     index of the current target entry
//   owvstate   sequencer state: 0=IDLE 1=FADE 2=HOLD
module rgb_fade_sequencer #(
  parameter int TICK_DIV   = 12000,
  parameter int HOLD_TICKS = 500
) (
  input  logic        iclk,
  input  logic        irst_n,
  input  logic        ienable,
  input  logic        iwr,
  input  logic [1:0]  iwvwaddr,
  input  logic [23:0] iwvwdata,
  output logic [23:0] owvduty,
  output logic [2:0]  owvrgbled,
  output logic [1:0]  owvidx,
  output logic [1:0]  owvstate
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      idx_q, idx_d;
  logic [23:0]     duty_q, duty_d;
  logic [23:0]     table_q [4];
  logic [7:0]      carrier_q;
  logic [2:0]      led_q;

  logic            tick;
  logic [23:0]     tgt;

  // One unsigned step toward the target; saturates at the target so the
  // duty can never wrap.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] goal);
    if (cur < goal)      return cur + 8'd1;
    else if (cur > goal) return cur - 8'd1;
    else                 return cur;
  endfunction

  // Target is read from the registered table, so a write landing on a tick
  // only takes effect on the following tick.
  assign tgt  = table_q[idx_q];
  assign tick = (presc_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    duty_d  = duty_q;
    if (!ienable) begin
      // Freeze duty and index; prescaler and hold count start fresh.
      state_d = ST_IDLE;
      presc_d = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FADE;
          presc_d = '0;
          hold_d  = '0;
        end
        ST_FADE: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (duty_q == tgt) begin
              state_d = ST_HOLD;
              hold_d  = '0;
            end else begin
              duty_d = {step_toward(duty_q[23:16], tgt[23:16]),
                        step_toward(duty_q[15:8],  tgt[15:8]),
                        step_toward(duty_q[7:0],   tgt[7:0])};
            end
          end
        end
        ST_HOLD: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) begin
            if (hold_q == HOLD_LAST) begin
              idx_d   = idx_q + 2'd1;
              state_d = ST_FADE;
              hold_d  = '0;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      duty_q  <= duty_d;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      table_q[0] <= 24'hFF0000;
      table_q[1] <= 24'h00FF00;
      table_q[2] <= 24'h0000FF;
      table_q[3] <= 24'h000000;
    end else if (iwr) begin
      table_q[iwvwaddr] <= iwvwdata;
    end
  end

  // Free-running carrier; a channel is high while carrier < duty, so duty 00
  // is always low and duty FF is high 255 of 256 clocks.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      carrier_q <= '0;
      led_q     <= '0;
    end else begin
      carrier_q <= carrier_q + 8'd1;
      led_q     <= {carrier_q < duty_q[7:0],
                    carrier_q < duty_q[15:8],
                    carrier_q < duty_q[23:16]};
    end
  end

  assign owvduty   = duty_q;
  assign owvrgbled = led_q;
  assign owvidx    = idx_q;
  assign owvstate  = state_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with TICK_DIV=4, HOLD_TICKS=2.
module tb_rgb_fade_sequencer;

  logic        iclk;
  logic        irst_n;
  logic        ienable;
  logic        iwr;
  logic [1:0]  iwvwaddr;
  logic [23:0] iwvwdata;
  logic [23:0] owvduty;
  logic [2:0]  owvrgbled;
  logic [1:0]  owvidx;
  logic [1:0]  owvstate;

  int n_checks;
  int n_fail;
  logic [23:0] exp_q[$];

  rgb_fade_sequencer #(
    .TICK_DIV  (4),
    .HOLD_TICKS(2)
  ) dut (
    .iclk      (iclk),
    .irst_n    (irst_n),
    .ienable   (ienable),
    .iwr       (iwr),
    .iwvwaddr  (iwvwaddr),
    .iwvwdata  (iwvwdata),
    .owvduty   (owvduty),
    .owvrgbled (owvrgbled),
    .owvidx    (owvidx),
    .owvstate  (owvstate)
  );

  // Clock / reset
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Advance n clocks, land 1 time unit after the edge.
  task automatic clk_n(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic ticks(input int n);
    clk_n(4 * n);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    ienable = 1'b0;
    iwr     = 1'b0;
    irst_n  = 1'b0;
    #1;
    check_eq("rst_duty",  32'(owvduty),   32'h0);
    check_eq("rst_led",   32'(owvrgbled), 32'h0);
    check_eq("rst_idx",   32'(owvidx),    32'h0);
    check_eq("rst_state", 32'(owvstate),  32'h0);
    clk_n(2);
    irst_n = 1'b1;
  endtask

  initial begin
    int cnt_r, cnt_g, cnt_b;
    n_checks = 0;
    n_fail   = 0;
    ienable  = 1'b0;
    iwr      = 1'b0;
    iwvwaddr = 2'd0;
    iwvwdata = 24'h0;
    irst_n   = 1'b0;
    clk_n(3);
    irst_n = 1'b1;
    clk_n(1);

    // Idle with enable low
    for (int i = 0; i < 1000; i++) begin
      clk_n(1);
      check_eq("idle_hold", {owvduty, owvrgbled, owvidx, owvstate},
               {24'h0, 3'b000, 2'd0, 2'd0} );
    end

    // Fade to entry0
    ienable = 1'b1;
    clk_n(1);
    check_eq("enter_fade", 32'(owvstate), 32'd1);
    check_eq("fade_start_duty", 32'(owvduty), 32'h0);
    for (int k = 1; k <= 255; k++) begin
      ticks(1);
      check_eq("ramp_r", 32'(owvduty), 32'(k << 16));
    end
    ticks(1);
    check_eq("hold0_state", 32'(owvstate), 32'd2);
    check_eq("hold0_duty", 32'(owvduty), 32'hFF0000);
    ticks(1);
    check_eq("hold0_idx", 32'(owvidx), 32'd0);
    ticks(1);
    check_eq("adv1_idx", 32'(owvidx), 32'd1);
    check_eq("adv1_state", 32'(owvstate), 32'd1);

    // Entry0 -> entry1 through the expected queue
    for (int k = 1; k <= 255; k++)
      exp_q.push_back({8'(255 - k), 8'(k), 8'h00});
    while (exp_q.size() > 0) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      ticks(1);
      check_eq("ramp_rg", 32'(owvduty), 32'(e));
    end
    ticks(1);
    check_eq("hold1_state", 32'(owvstate), 32'd2);
    ticks(2);
    check_eq("adv2_idx", 32'(owvidx), 32'd2);

    for (int k = 1; k <= 255; k++) begin
      ticks(1);
      check_eq("ramp_gb", 32'(owvduty), 32'({8'h00, 8'(255 - k), 8'(k)}));
    end
    ticks(1);
    check_eq("hold2_state", 32'(owvstate), 32'd2);
    ticks(2);
    check_eq("adv3_idx", 32'(owvidx), 32'd3);

    for (int k = 1; k <= 255; k++) begin
      ticks(1);
      check_eq("ramp_b_down", 32'(owvduty), 32'(255 - k));
    end
    ticks(1);
    check_eq("hold3_state", 32'(owvstate), 32'd2);
    check_eq("hold3_duty", 32'(owvduty), 32'h0);
    ticks(2);
    check_eq("wrap_idx", 32'(owvidx), 32'd0);
    check_eq("wrap_state", 32'(owvstate), 32'd1);
    for (int k = 1; k <= 'h40; k++) begin
      ticks(1);
      check_eq("rewrap_ramp_r", 32'(owvduty), 32'(k << 16));
    end

    // Drop enable at R=0x40
    ienable = 1'b0;
    clk_n(1);
    check_eq("drop_state", 32'(owvstate), 32'd0);
    check_eq("drop_duty", 32'(owvduty), 32'h400000);
    for (int i = 0; i < 500; i++) begin
      clk_n(1);
      check_eq("frozen", {6'd0, owvduty, owvstate}, {6'd0, 24'h400000, 2'd0});
    end
    ienable = 1'b1;
    clk_n(1);
    check_eq("resume_state", 32'(owvstate), 32'd1);
    clk_n(3);
    check_eq("resume_pre_tick", 32'(owvduty), 32'h400000);
    clk_n(1);
    check_eq("resume_tick", 32'(owvduty), 32'h410000);

    // Retarget mid-fade, write landing on a tick
    apply_reset();
    ienable = 1'b1;
    clk_n(1);
    check_eq("rt_fade", 32'(owvstate), 32'd1);
    ticks(32);
    check_eq("rt_at20", 32'(owvduty), 32'h200000);
    clk_n(3);
    iwr      = 1'b1;
    iwvwaddr = 2'd0;
    iwvwdata = 24'h100000;
    clk_n(1);
    iwr = 1'b0;
    check_eq("rt_old_target_step", 32'(owvduty), 32'h210000);
    for (int k = 1; k <= 17; k++) begin
      ticks(1);
      check_eq("rt_ramp_down", 32'(owvduty), 32'((8'h21 - k) << 16));
    end
    ticks(1);
    check_eq("rt_hold_state", 32'(owvstate), 32'd2);
    check_eq("rt_hold_duty", 32'(owvduty), 32'h100000);

    // PWM at constant duty 800000
    apply_reset();
    for (int a = 0; a < 4; a++) begin
      iwr      = 1'b1;
      iwvwaddr = 2'(a);
      iwvwdata = 24'h800000;
      clk_n(1);
    end
    iwr     = 1'b0;
    ienable = 1'b1;
    clk_n(1);
    ticks(16'h81);
    check_eq("pwm_hold_state", 32'(owvstate), 32'd2);
    clk_n(20);
    check_eq("pwm_duty_start", 32'(owvduty), 32'h800000);
    cnt_r = 0;
    cnt_g = 0;
    cnt_b = 0;
    for (int i = 0; i < 256; i++) begin
      clk_n(1);
      cnt_r += int'(owvrgbled[0]);
      cnt_g += int'(owvrgbled[1]);
      cnt_b += int'(owvrgbled[2]);
    end
    check_eq("pwm_r_high", 32'(cnt_r), 32'd128);
    check_eq("pwm_g_high", 32'(cnt_g), 32'd0);
    check_eq("pwm_b_high", 32'(cnt_b), 32'd0);
    check_eq("pwm_duty_end", 32'(owvduty), 32'h800000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
